// File: rtl/axis_spi_pkg.sv
// axis_spi_pkg: shared state type and round-robin helper for the SPI arbiter
package axis_spi_pkg;
  typedef enum logic [1:0] {IDLE, ARB, XFER, DRAIN} arb_state_t;
  localparam int RR_MAX = 8;
  function automatic logic [RR_MAX-1:0] rr_pick(input logic [RR_MAX-1:0] req, input logic [2:0] last_ptr, input int n);
    logic [RR_MAX-1:0] r;
    int idx;
    r = '0;
    for (int i = n; i >= 1; i--) begin
      idx = (int'(last_ptr) + i) % n;
      if (req[idx[2:0]]) r = RR_MAX'(1) << idx;
    end
    return r;
  endfunction
endpackage

// File: rtl/axis_if.sv
// axis_if: AXI-Stream byte channel between the arbiter and the SPI master
interface axis_if #(parameter int DATA_WIDTH = 8);
  logic tvalid;
  logic tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic tlast;
  modport master(output tvalid, tdata, tlast, input tready);
  modport slave(input tvalid, tdata, tlast, output tready);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick with a registered last-served pointer
module rr_arbiter import axis_spi_pkg::*; #(
  parameter int N = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] req_i,
  input  logic         upd_i,
  input  logic [N-1:0] upd_grant_i,
  output logic [N-1:0] pick_o
);
  localparam int PW = $clog2(N);
  logic [PW-1:0] last_ptr_q, last_ptr_d;
  assign pick_o = N'(rr_pick(RR_MAX'(req_i), 3'(last_ptr_q), N));
  // on release the pointer moves to the requester whose grant is being dropped
  always_comb begin
    last_ptr_d = last_ptr_q;
    for (int i = 0; i < N; i++) last_ptr_d = (upd_i && upd_grant_i[i]) ? PW'(i) : last_ptr_d;
  end
  // pointer register; reset leaves requester 0 as the first choice
  always_ff @(posedge clk_i) last_ptr_q <= rst_i ? PW'(N - 1) : last_ptr_d;
endmodule

// File: rtl/axis_spi_arbiter.sv
// axis_spi_arbiter: round-robin sharing of one SPI master among AXI-Stream requesters
module axis_spi_arbiter import axis_spi_pkg::*; #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 8,
  parameter int SLAVE_NUM  = 2,
  parameter int TIMEOUT    = 4096,
  localparam int ADDR_W    = SLAVE_NUM > 1 ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_tvalid_i,
  output logic [NUM_REQ-1:0]            req_tready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_tdata_i,
  input  logic [NUM_REQ-1:0]            req_tlast_i,
  input  logic [NUM_REQ*ADDR_W-1:0]     req_addr_i,
  output logic [NUM_REQ-1:0]            rsp_tvalid_o,
  input  logic [NUM_REQ-1:0]            rsp_tready_i,
  output logic [DATA_WIDTH-1:0]         rsp_tdata_o,
  output logic                          rsp_tlast_o,
  output logic [ADDR_W-1:0]             spi_addr_o,
  axis_if.master                        m_axis,
  axis_if.slave                         s_axis,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          timeout_o
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int WD_W = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  arb_state_t state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, pick;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [GW-1:0] g, p;
  logic act, req_hs, rsp_hs, req_end, rsp_end, done, wd_fire, release_w;
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_i       (req_tvalid_i),
    .upd_i       (release_w),
    .upd_grant_i (grant_q),
    .pick_o      (pick)
  );
  assign act = state_q == XFER || state_q == DRAIN;
  assign req_hs = m_axis.tvalid && m_axis.tready;
  assign rsp_hs = s_axis.tvalid && s_axis.tready;
  assign req_end = req_hs && m_axis.tlast;
  assign rsp_end = rsp_hs && s_axis.tlast;
  assign done = rsp_end && (state_q == DRAIN || req_end);
  assign wd_fire = TIMEOUT != 0 && act && wd_q == WD_MAX && !req_hs && !rsp_hs;
  assign release_w = done || wd_fire;
  assign grant_o = grant_q;
  assign spi_addr_o = addr_q;
  assign busy_o = state_q != IDLE;
  assign timeout_o = wd_fire;
  // binary indices of the held grant and of the fresh round-robin pick
  always_comb begin
    g = '0;
    p = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      g = grant_q[i] ? GW'(i) : g;
      p = pick[i] ? GW'(i) : p;
    end
  end
  // state register; reset abandons any frame in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      grant_q <= '0;
      addr_q <= '0;
      wd_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
    end
  end
  // next state: lock grant and address in ARB, release on response end or watchdog
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d = addr_q;
    wd_d = (req_hs || rsp_hs) ? '0 : wd_q + 1'b1;
    case (state_q)
      IDLE: state_d = |req_tvalid_i ? ARB : IDLE;
      ARB: begin
        state_d = |pick ? XFER : IDLE;
        grant_d = pick;
        addr_d = |pick ? req_addr_i[int'(p)*ADDR_W +: ADDR_W] : addr_q;
        wd_d = '0;
      end
      default: begin
        state_d = release_w ? IDLE : (req_end ? DRAIN : state_q);
        grant_d = release_w ? '0 : grant_q;
      end
    endcase
  end
  // combinational pass-through of the granted requester in both directions
  always_comb begin
    m_axis.tvalid = state_q == XFER && req_tvalid_i[g];
    m_axis.tdata = req_tdata_i[int'(g)*DATA_WIDTH +: DATA_WIDTH];
    m_axis.tlast = req_tlast_i[g];
    req_tready_o = state_q == XFER ? grant_q & {NUM_REQ{m_axis.tready}} : '0;
    s_axis.tready = act && rsp_tready_i[g];
    rsp_tvalid_o = act ? grant_q & {NUM_REQ{s_axis.tvalid}} : '0;
    rsp_tdata_o = s_axis.tdata;
    rsp_tlast_o = s_axis.tlast;
  end
endmodule

// File: tb/tb_axis_spi_arbiter.sv
// tb_axis_spi_arbiter: directed stimulus checked against a cycle-level behavioural model
module tb_axis_spi_arbiter;
  localparam int N = 3, DW = 8, AW = 1, TO = 16;
  logic clk = 0, rst = 1;
  logic [N-1:0] rv = '0, rl = '0, rrdy = '1;
  logic [N*DW-1:0] rd = '0;
  logic [N*AW-1:0] ra = 3'b010;
  logic [N-1:0] rsp_tvalid, req_tready, grant;
  logic [DW-1:0] rsp_tdata;
  logic rsp_tlast, busy, tmo;
  logic [AW-1:0] spi_addr;
  int total = 0, bad = 0, tcount = 0, cnum = 0, hs_cyc = 0, to_cyc = 0;
  bit rsp_en = 1;
  logic [8:0] reqq[N][$];
  logic [8:0] rspq[$];
  int sent_log[$], rsp_log[$], glog[$], alog[$];
  axis_if #(DW) m_if();
  axis_if #(DW) s_if();
  axis_spi_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .SLAVE_NUM(2), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_tvalid_i(rv), .req_tready_o(req_tready), .req_tdata_i(rd), .req_tlast_i(rl), .req_addr_i(ra),
    .rsp_tvalid_o(rsp_tvalid), .rsp_tready_i(rrdy), .rsp_tdata_o(rsp_tdata), .rsp_tlast_o(rsp_tlast),
    .spi_addr_o(spi_addr), .m_axis(m_if), .s_axis(s_if),
    .grant_o(grant), .busy_o(busy), .timeout_o(tmo)
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, a, e, $time);
    end
  endtask

  task automatic chk_q(input string nm, input int got[$], input int exp[$]);
    chk({nm, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) chk(nm, i < got.size() ? got[i] : -1, exp[i]);
  endtask

  // model: owner (-1 none), pending arbitration, request-frame-sent flag, quiet-cycle count
  int m_own = -1, m_last = N - 1, m_addr = 0, m_quiet = 0;
  bit m_arb = 0, m_sent = 0, armed = 0;
  function automatic bit own_bit(input logic [N-1:0] v);
    return m_own >= 0 ? v[m_own] : 1'b0;
  endfunction
  function automatic bit m_rq();
    return m_own >= 0 && !m_sent && own_bit(rv) && m_if.tready;
  endfunction
  function automatic bit m_rs();
    return m_own >= 0 && s_if.tvalid && own_bit(rrdy);
  endfunction
  function automatic bit m_fire();
    return m_own >= 0 && !m_rq() && !m_rs() && m_quiet == TO - 1;
  endfunction

  always @(posedge clk) begin
    bit rq, rs, rqe, rse, fire;
    rq = m_rq();
    rs = m_rs();
    fire = m_fire();
    rqe = rq && own_bit(rl);
    rse = rs && s_if.tlast;
    if (rst) begin
      m_own = -1; m_arb = 0; m_last = N - 1; m_addr = 0; armed = 1;
    end else if (m_arb) begin
      m_arb = 0;
      for (int i = N; i >= 1; i--) if (rv[(m_last + i) % N]) m_own = (m_last + i) % N;
      if (m_own >= 0) begin
        m_addr = int'(ra[m_own*AW +: AW]); m_sent = 0; m_quiet = 0;
      end
    end else if (m_own < 0) begin
      m_arb = |rv;
    end else if ((rse && (m_sent || rqe)) || fire) begin
      m_last = m_own; m_own = -1;
    end else begin
      if (rqe) m_sent = 1;
      m_quiet = (rq || rs) ? 0 : m_quiet + 1;
    end
  end

  always @(negedge clk) if (armed) begin
    logic [N-1:0] eg;
    eg = m_own >= 0 ? N'(1) << m_own : '0;
    chk("grant", grant, eg);
    chk("busy", busy, m_own >= 0 || m_arb);
    chk("spi_addr", spi_addr, m_addr);
    chk("m_tvalid", m_if.tvalid, m_own >= 0 && !m_sent && own_bit(rv));
    if (m_own >= 0 && m_if.tvalid) chk("m_tdata", {m_if.tlast, m_if.tdata}, {own_bit(rl), rd[m_own*DW +: DW]});
    chk("req_tready", req_tready, (m_own >= 0 && !m_sent && m_if.tready) ? eg : '0);
    chk("rsp_tvalid", rsp_tvalid, s_if.tvalid ? eg : '0);
    chk("s_tready", s_if.tready, m_own >= 0 && own_bit(rrdy));
    if (s_if.tvalid) chk("rsp_data", {rsp_tlast, rsp_tdata}, {s_if.tlast, s_if.tdata});
    chk("timeout", tmo, m_fire());
  end

  // requester and SPI-master side engine: observe at negedge, update queues after the edge
  initial begin
    logic [N-1:0] pop;
    logic [N-1:0] gprev;
    logic mh, sh;
    logic [8:0] mb;
    gprev = '0;
    m_if.tready = 1; s_if.tvalid = 0; s_if.tdata = '0; s_if.tlast = 0;
    forever begin
      @(negedge clk);
      cnum++;
      pop = rv & req_tready;
      mh = m_if.tvalid && m_if.tready;
      sh = s_if.tvalid && s_if.tready;
      mb = {m_if.tlast, m_if.tdata};
      if (mh) begin sent_log.push_back(int'(mb)); hs_cyc = cnum; end
      if (sh) rsp_log.push_back(int'(grant) * 512 + int'({s_if.tlast, s_if.tdata}));
      if (tmo) begin tcount++; to_cyc = cnum; end
      if (grant != gprev && grant != '0) begin glog.push_back(int'(grant)); alog.push_back(int'(spi_addr)); end
      gprev = grant;
      @(posedge clk); #2;
      for (int k = 0; k < N; k++) if (pop[k] && reqq[k].size() > 0) void'(reqq[k].pop_front());
      if (mh) rspq.push_back({mb[8], ~mb[7:0]});
      if (sh && rspq.size() > 0) void'(rspq.pop_front());
      for (int k = 0; k < N; k++) begin
        rv[k] = reqq[k].size() > 0;
        {rl[k], rd[k*DW +: DW]} = rv[k] ? reqq[k][0] : 9'h0;
      end
      s_if.tvalid = rsp_en && rspq.size() > 0;
      {s_if.tlast, s_if.tdata} = rspq.size() > 0 ? rspq[0] : 9'h0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic settle(input string nm);
    int b = 0;
    @(negedge clk);
    while (b < 300 && (busy || rspq.size() != 0 || reqq[0].size() + reqq[1].size() + reqq[2].size() != 0)) begin
      @(negedge clk); b++;
    end
    chk({nm, "_settle"}, b < 300, 1);
    @(posedge clk); #1;
  endtask
  task automatic wait_grant(input logic [N-1:0] gw, input string nm);
    int b = 0;
    @(negedge clk);
    while (b < 100 && grant != gw) begin @(negedge clk); b++; end
    chk({nm, "_grant_wait"}, b < 100, 1);
    @(posedge clk); #1;
  endtask
  task automatic clear_logs();
    sent_log.delete(); rsp_log.delete(); glog.delete(); alog.delete();
  endtask

  initial begin
    int e[$];
    int b;
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addr", spi_addr, 0);
    chk("rst_tmo", tmo, 0);
    chk("rst_mvalid", m_if.tvalid, 0);
    @(posedge clk); #1;
    rst = 0;
    cyc(2);
    // single requester 1, two-byte frame
    reqq[1].push_back(9'h0A5); reqq[1].push_back(9'h13C);
    settle("t1");
    e = '{2}; chk_q("t1_grant", glog, e);
    e = '{1}; chk_q("t1_addr", alog, e);
    e = '{9'h0A5, 9'h13C}; chk_q("t1_sent", sent_log, e);
    e = '{2*512 + 9'h05A, 2*512 + 9'h1C3}; chk_q("t1_rsp", rsp_log, e);
    clear_logs();
    // all three requesters continuously valid, one-byte frames
    rst = 1; cyc(1); rst = 0;
    for (int k = 0; k < N; k++) begin
      reqq[k].push_back(9'h100 | 9'(16*(k+1)));
      reqq[k].push_back(9'h101 | 9'(16*(k+1)));
    end
    settle("t2");
    e = '{1, 2, 4, 1, 2, 4}; chk_q("t2_grant", glog, e);
    e = '{0, 1, 0, 0, 1, 0}; chk_q("t2_addr", alog, e);
    e = '{9'h110, 9'h120, 9'h130, 9'h111, 9'h121, 9'h131}; chk_q("t2_sent", sent_log, e);
    clear_logs();
    // requester 2 arrives mid-frame of requester 0 and must wait
    reqq[0].push_back(9'h001); reqq[0].push_back(9'h002); reqq[0].push_back(9'h003); reqq[0].push_back(9'h104);
    wait_grant(3'b001, "t3");
    reqq[2].push_back(9'h10E);
    settle("t3");
    e = '{1, 4}; chk_q("t3_grant", glog, e);
    e = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h10E}; chk_q("t3_sent", sent_log, e);
    clear_logs();
    // backpressure on both the request and the response side
    reqq[1].push_back(9'h081); reqq[1].push_back(9'h082); reqq[1].push_back(9'h083); reqq[1].push_back(9'h184);
    b = 0;
    while (sent_log.size() < 2 && b < 100) begin cyc(1); b++; end
    chk("t4_start", b < 100, 1);
    m_if.tready = 0; cyc(5); m_if.tready = 1;
    rrdy[1] = 0; cyc(3); rrdy[1] = 1;
    settle("t4");
    e = '{2}; chk_q("t4_grant", glog, e);
    e = '{9'h081, 9'h082, 9'h083, 9'h184}; chk_q("t4_sent", sent_log, e);
    e = '{2*512 + 9'h07E, 2*512 + 9'h07D, 2*512 + 9'h07C, 2*512 + 9'h17B}; chk_q("t4_rsp", rsp_log, e);
    clear_logs();
    // stalled SPI response trips the watchdog
    rsp_en = 0; tcount = 0;
    reqq[0].push_back(9'h155);
    b = 0;
    while (tcount == 0 && b < 100) begin cyc(1); b++; end
    chk("t5_fired", b < 100, 1);
    chk("t5_delay", to_cyc - hs_cyc, 16);
    cyc(3);
    chk("t5_pulses", tcount, 1);
    chk("t5_idle", busy, 0);
    rspq.delete(); rsp_en = 1;
    reqq[0].push_back(9'h166); reqq[1].push_back(9'h177);
    settle("t5");
    e = '{1, 2, 1}; chk_q("t5_grant", glog, e);
    chk("t5_pulses_end", tcount, 1);
    clear_logs();
    // reset during the transfer of requester 1
    m_if.tready = 0;
    reqq[1].push_back(9'h091); reqq[1].push_back(9'h092); reqq[1].push_back(9'h193);
    wait_grant(3'b010, "t6");
    rst = 1; cyc(1);
    chk("t6_grant", grant, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", req_tready, 0);
    chk("t6_mvalid", m_if.tvalid, 0);
    for (int k = 0; k < N; k++) reqq[k].delete();
    rspq.delete(); m_if.tready = 1;
    cyc(1);
    clear_logs();
    rst = 0;
    reqq[0].push_back(9'h1A0); reqq[1].push_back(9'h1A1);
    settle("t6");
    e = '{1, 2}; chk_q("t6_order", glog, e);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench did not finish");
  end
endmodule

// File: doc/axis_spi_arbiter.md
Name: axis_spi_arbiter

Overview:
- Shares one axis_spi_master between NUM_REQ AXI-Stream requesters using round-robin arbitration.
- Each requester supplies a frame of bytes (tlast terminates the frame) plus a target chip-select address.
- The arbiter locks the grant and the SPI address for a whole frame, including its response.
- It routes the SPI master's receive stream back to the granted requester only.
- Sits between the system command sources and the SPI master, driving the master's addr_i, s_axis and m_axis.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- DATA_WIDTH, 8, byte width; must match the SPI master.
- SLAVE_NUM, 2, number of SPI slaves; ADDR_W = max(1, $clog2(SLAVE_NUM)).
- TIMEOUT, 4096, watchdog cycles without any handshake while locked; 0 disables the watchdog.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, synchronous, active-high.
- req_tvalid_i  in  NUM_REQ  per-requester tx valid.
- req_tready_o  out  NUM_REQ  per-requester tx ready.
- req_tdata_i  in  NUM_REQ*DATA_WIDTH  packed tx data; requester k occupies slice k.
- req_tlast_i  in  NUM_REQ  last byte of frame.
- req_addr_i  in  NUM_REQ*ADDR_W  packed target slave address per requester.
- rsp_tvalid_o  out  NUM_REQ  response valid; only the granted bit can be high.
- rsp_tready_i  in  NUM_REQ  response ready.
- rsp_tdata_o  out  DATA_WIDTH  shared response data.
- rsp_tlast_o  out  1  shared response last.
- spi_addr_o  out  ADDR_W  to SPI master addr_i.
- m_axis  axis_if.master  DATA_WIDTH  to SPI master s_axis.
- s_axis  axis_if.slave  DATA_WIDTH  from SPI master m_axis.
- grant_o  out  NUM_REQ  one-hot current grant; 0 when idle.
- busy_o  out  1  high while in ARB, XFER or DRAIN.
- timeout_o  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset (rst_i sampled high at a clock edge):
  - state=IDLE, grant_o=0, spi_addr_o=0, busy_o=0, timeout_o=0.
  - All tvalid/tready outputs are 0.
  - last_ptr=NUM_REQ-1, so requester 0 has highest priority first.
  - Reset mid-frame abandons the frame immediately.
- States:
  - IDLE: if any req_tvalid_i is high, go to ARB.
  - ARB (1 cycle): select the first valid requester searching from last_ptr+1 mod NUM_REQ upward with wrap. Register the one-hot grant and latch that requester's req_addr_i into spi_addr_o; spi_addr_o then stays stable until the next ARB. Go to XFER.
    - If the selected requester's valid has dropped by the ARB cycle, return to IDLE without granting.
  - XFER: pass the granted request through combinationally.
    - m_axis.tvalid = req_tvalid_i[g]; m_axis.tdata/tlast = slice g.
    - req_tready_o[g] = m_axis.tready; all other req_tready_o bits are 0.
    - A handshake with tlast=1 moves to DRAIN.
  - DRAIN: m_axis.tvalid=0 and all req_tready_o=0. Wait for the response frame end.
  - Response path, active in XFER and DRAIN:
    - rsp_tvalid_o[g] = s_axis.tvalid; s_axis.tready = rsp_tready_i[g].
    - rsp_tdata_o/rsp_tlast_o = s_axis.tdata/tlast.
    - s_axis.tready=0 in IDLE and ARB.
  - A response handshake with tlast=1 moves to IDLE: last_ptr=g, grant_o cleared.
    - This takes effect only in DRAIN, or in XFER on the same cycle as the request tlast handshake.
    - An earlier response tlast in XFER is forwarded but does not end the lock.
- Latency:
  - Request valid to grant_o: 2 cycles from IDLE (IDLE→ARB→XFER).
  - Data pass-through: 0 cycles.
  - Frame end to next grant: at least 2 cycles (IDLE, ARB).
- Watchdog:
  - wd_cnt clears on any request or response handshake and on entry to XFER; it increments in XFER/DRAIN.
  - At TIMEOUT-1: pulse timeout_o, go to IDLE, set last_ptr=g.
  - Response beats arriving afterwards in IDLE are not accepted (s_axis.tready=0).
- Fairness:
  - A requester that holds valid is served within NUM_REQ frames.
  - A new request arriving during a lock waits; no preemption.
- Simultaneous events:
  - Request tlast and response tlast in the same XFER cycle → IDLE directly.
  - Watchdog expiry on the same cycle as a completing handshake → the handshake wins and timeout_o stays 0.

Decomposition:
- Package axis_spi_pkg holds:
  - arb_state_t enum {IDLE, ARB, XFER, DRAIN} (2 bits);
  - function rr_pick(req, last_ptr), returning a one-hot result.
- One sub-module, rr_arbiter: combinational round-robin pick plus the registered last_ptr update. It is reusable by future multi-master controllers.

Test Plan:
- Single requester 1, addr=1, frame {0xA5,0x3C} with tlast on 0x3C:
  - grant_o=3'b010 and spi_addr_o=1 throughout;
  - the bytes appear on m_axis unchanged;
  - the 2 response beats reach rsp_tvalid_o[1] only;
  - return to IDLE after the response tlast.
- All 3 requesters valid continuously, 1-byte frames each: grant order 0,1,2,0,1,2; spi_addr_o tracks each requester's address.
- Requester 2 raises valid mid-frame of requester 0: requester 0 tready stays active, requester 2 tready stays 0 until requester 0's response tlast, then requester 2 is granted.
- Backpressure: m_axis.tready=0 for 5 cycles mid-frame, then rsp_tready_i[g]=0 for 3 cycles → no beat lost or duplicated; wd_cnt clears on each resumed handshake.
- TIMEOUT=16 with a stalled SPI response: timeout_o pulses exactly once at the 16th idle cycle in DRAIN; next grant goes to the following requester.
- rst_i asserted during XFER of requester 1 → next cycle all outputs are at reset values; requester 0 wins first after release.
